// File: rtl/lsu_pkg.sv
// Shared load/store unit definitions: funct3 codes, FSM states and lane helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        REQ0,
        WAIT0,
        REQ1,
        WAIT1,
        RESP
    } state_t;

    function automatic logic [3:0] lane_mask(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: lane_mask = 4'b0001;
            F3_H, F3_HU: lane_mask = 4'b0011;
            default:     lane_mask = 4'b1111;
        endcase
    endfunction

    // Stores have no unsigned variants, so anything above word is illegal.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        if (we) begin
            f3_illegal = (f3 > F3_W);
        end else begin
            f3_illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for one memory beat and load reassembly/extension.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic        beat,
    input  logic [31:0] wdata,
    input  logic [31:0] rd_lo,
    input  logic [31:0] rd_hi,
    output logic        split,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata
);

    logic [7:0]  be_wide;
    logic [63:0] wd_wide;
    logic [63:0] rd_shift;
    logic [31:0] raw;

    always_comb begin
        split = ((funct3 == F3_H || funct3 == F3_HU) && off == 2'd3) ||
                (funct3 == F3_W && off != 2'd0);

        // Shifting into a double-width vector gives beat 1 the lanes that spill past the word.
        be_wide  = {4'b0000, lane_mask(funct3)} << off;
        wd_wide  = {32'h0, wdata} << {off, 3'b000};
        be         = beat ? be_wide[7:4]  : be_wide[3:0];
        wdata_lane = beat ? wd_wide[63:32] : wd_wide[31:0];

        rd_shift = {rd_hi, rd_lo} >> {off, 3'b000};
        raw      = rd_shift[31:0];
        case (funct3)
            F3_B:    rdata = {{24{raw[7]}}, raw[7:0]};
            F3_H:    rdata = {{16{raw[15]}}, raw[15:0]};
            F3_BU:   rdata = {24'h0, raw[7:0]};
            F3_HU:   rdata = {16'h0, raw[15:0]};
            default: rdata = raw;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: splits unaligned accesses into word beats with byte enables.
// Latency: store 2/3 cycles, load 3/5 cycles (aligned/split), +1 per gnt/rvalid stall.
// Backpressure: one request in flight; req_ready only in IDLE, no response backpressure.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [2:0]            f3_q, f3_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] beat0_q, beat0_d;
    logic [DATA_WIDTH-1:0] beat1_q, beat1_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

    logic                  split;
    logic                  in_req;
    logic                  in_mem;
    logic [3:0]            lane_be;
    logic [DATA_WIDTH-1:0] lane_wdata;
    logic [DATA_WIDTH-1:0] rd_lo;
    logic [DATA_WIDTH-1:0] rd_hi;
    logic [DATA_WIDTH-1:0] ld_data;
    logic [ADDR_WIDTH-1:0] base_addr;

    assign in_req    = (state_q == REQ0) || (state_q == REQ1);
    assign in_mem    = in_req || (state_q == WAIT0) || (state_q == WAIT1);
    assign base_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};

    // Bypass the arriving beat so the final load word is ready on the edge into RESP.
    assign rd_lo = (state_q == WAIT0) ? mem_rdata : beat0_q;
    assign rd_hi = (state_q == WAIT1) ? mem_rdata : beat1_q;

    lsu_lane_align u_lane_align (
        .funct3     (f3_q),
        .off        (addr_q[1:0]),
        .beat       (state_q == REQ1),
        .wdata      (wdata_q),
        .rd_lo      (rd_lo),
        .rd_hi      (rd_hi),
        .split      (split),
        .be         (lane_be),
        .wdata_lane (lane_wdata),
        .rdata      (ld_data)
    );

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        f3_d        = f3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        beat0_d     = beat0_q;
        beat1_d     = beat1_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (f3_illegal(req_we, req_funct3)) begin
                        state_d     = RESP;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d = REQ0;
                    end
                end
            end
            REQ0: begin
                if (mem_gnt) begin
                    if (!we_q)      state_d = WAIT0;
                    else if (split) state_d = REQ1;
                    else            state_d = RESP;
                end
            end
            WAIT0: begin
                if (mem_rvalid) begin
                    beat0_d = mem_rdata;
                    state_d = split ? REQ1 : RESP;
                end
            end
            REQ1: begin
                if (mem_gnt) state_d = we_q ? RESP : WAIT1;
            end
            WAIT1: begin
                if (mem_rvalid) begin
                    beat1_d = mem_rdata;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (in_mem && state_d == RESP) begin
            rsp_err_d   = 1'b0;
            rsp_rdata_d = we_q ? '0 : ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= '0;
            beat0_q     <= '0;
            beat1_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            beat0_q     <= beat0_d;
            beat1_q     <= beat1_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Memory outputs are zero outside REQ* so they reset with the state register.
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mem_req   = in_req;
    assign mem_we    = in_req & we_q;
    assign mem_be    = in_req ? lane_be : 4'b0000;
    assign mem_addr  = !in_req ? '0 :
                       (state_q == REQ1) ? base_addr + ADDR_WIDTH'(4) : base_addr;
    assign mem_wdata = (in_req && we_q) ? lane_wdata : '0;

endmodule
